// File: rtl/iob_regfile_2p_reader_pkg.sv
// Shared FSM encodings for the iob_regfile_2p_reader read-out engine.
package iob_regfile_2p_reader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/iob_regfile_2p_reader_if.sv
// Valid/ready output stream of the register-file reader (master = reader, slave = consumer).
interface iob_regfile_2p_reader_if #(
  parameter int W = 32
) ();

  logic [W-1:0] m_tdata_o;
  logic         m_tvalid_o;
  logic         m_tlast_o;
  logic         m_tready_i;

  modport master (
    output m_tdata_o,
    output m_tvalid_o,
    output m_tlast_o,
    input  m_tready_i
  );

  modport slave (
    input  m_tdata_o,
    input  m_tvalid_o,
    input  m_tlast_o,
    output m_tready_i
  );

endinterface

// File: rtl/iob_regfile_2p_reader_addr_gen.sv
// Read pointer / remaining-count tracker with wrap or clamp of the request.
// Wrap-around reads are enabled by defining IOB_REGFILE_2P_READER_WRAP_EN.
module iob_regfile_2p_reader_addr_gen #(
  parameter int N       = 8,
  parameter int RADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_i,
  input  logic               adv_i,
  input  logic [RADDR_W-1:0] first_i,
  input  logic [RADDR_W:0]   count_i,
  output logic [RADDR_W-1:0] ptr_o,
  output logic               last_o,
  output logic               empty_o
);

  localparam logic [RADDR_W:0]   NCNT     = (RADDR_W + 1)'(N);
  localparam logic [RADDR_W-1:0] LAST_IDX = RADDR_W'(N - 1);

  logic [RADDR_W-1:0] ptr_q, ptr_d;
  logic [RADDR_W:0]   rem_q, rem_d;
  logic [RADDR_W:0]   cnt_clamp;
  logic [RADDR_W:0]   eff_cnt;
  logic               first_oob;

`ifdef IOB_REGFILE_2P_READER_WRAP_EN
  always_comb begin
    cnt_clamp = (count_i > NCNT) ? NCNT : count_i;
    eff_cnt   = cnt_clamp;
  end
`else
  logic [RADDR_W:0] avail;

  // avail underflows when first_i >= N, but that case is already reported empty.
  always_comb begin
    cnt_clamp = (count_i > NCNT) ? NCNT : count_i;
    avail     = NCNT - {1'b0, first_i};
    eff_cnt   = (cnt_clamp > avail) ? avail : cnt_clamp;
  end
`endif

  assign first_oob = ({1'b0, first_i} >= NCNT);
  assign empty_o   = first_oob || (eff_cnt == '0);

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (init_i) begin
      ptr_d = first_i;
      rem_d = empty_o ? '0 : eff_cnt;
    end else if (adv_i) begin
      ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (rem_q == (RADDR_W + 1)'(1));

endmodule

// File: rtl/iob_regfile_2p_reader.sv
// Streams a run of consecutive iob_regfile_2p registers as a valid/ready packet.
// Build option: IOB_REGFILE_2P_READER_WRAP_EN (reads wrap past N-1 instead of stopping).
module iob_regfile_2p_reader
  import iob_regfile_2p_reader_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int RADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                        clk_i,
  input  logic                        cen_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [RADDR_W-1:0]          first_i,
  input  logic [RADDR_W:0]            count_i,
  output logic [RADDR_W-1:0]          raddr_o,
  input  logic [W-1:0]                rdata_i,
  iob_regfile_2p_reader_if.master     m_axis,
  output logic                        busy_o,
  output logic                        done_o
);

  state_t       state_q;
  logic [W-1:0] tdata_q;
  logic         tvalid_q;
  logic         tlast_q;
  logic         done_q;

  logic ld;
  logic init;
  logic adv;
  logic last;
  logic empty;

  assign ld   = !tvalid_q || m_axis.m_tready_i;
  assign init = cen_i && (state_q == ST_IDLE) && start_i;
  assign adv  = cen_i && (state_q == ST_FETCH) && ld;

  iob_regfile_2p_reader_addr_gen #(
    .N       (N),
    .RADDR_W (RADDR_W)
  ) u_addr_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .init_i  (init),
    .adv_i   (adv),
    .first_i (first_i),
    .count_i (count_i),
    .ptr_o   (raddr_o),
    .last_o  (last),
    .empty_o (empty)
  );

  // The beat register only reloads when the current beat is absent or being taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (cen_i) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (empty) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (ld) begin
            tdata_q  <= rdata_i;
            tvalid_q <= 1'b1;
            tlast_q  <= last;
            if (last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tvalid_q && m_axis.m_tready_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis.m_tdata_o  = tdata_q;
  assign m_axis.m_tvalid_o = tvalid_q;
  assign m_axis.m_tlast_o  = tlast_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = done_q;

endmodule

// File: tb/tb_iob_regfile_2p_reader.sv
// Directed, table-driven bench for iob_regfile_2p_reader with an 8-entry register file model.
module tb_iob_regfile_2p_reader;

  localparam int N = 8;
  localparam int W = 32;
  localparam int RADDR_W = 3;

  logic               clk_i = 1'b0;
  logic               cen_i;
  logic               rst_i;
  logic               start_i;
  logic [RADDR_W-1:0] first_i;
  logic [RADDR_W:0]   count_i;
  logic [RADDR_W-1:0] raddr_o;
  logic [W-1:0]       rdata_i;
  logic               busy_o;
  logic               done_o;

  logic [W-1:0] regs [N];

  int total = 0;
  int bad   = 0;

  iob_regfile_2p_reader_if #(.W(W)) m_if ();

  iob_regfile_2p_reader #(
    .N       (N),
    .W       (W),
    .RADDR_W (RADDR_W)
  ) dut (
    .clk_i   (clk_i),
    .cen_i   (cen_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .first_i (first_i),
    .count_i (count_i),
    .raddr_o (raddr_o),
    .rdata_i (rdata_i),
    .m_axis  (m_if),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  assign rdata_i = regs[raddr_o];

  typedef struct {
    logic [2:0]  first;
    logic [3:0]  count;
    int          n;
    logic [31:0] idx;   // expected register indices, one per nibble, beat 0 in bits [3:0]
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; rdy_pat/cenlo_pat give per-cycle ready and cen-low, indexed from the start cycle.
  task automatic run_req(input string name, input logic [2:0] f, input logic [3:0] c,
                         input logic [31:0] rdy_pat, input logic [31:0] cenlo_pat,
                         input int inj_idx, input logic [31:0] exp_idx, input int exp_n);
    int          nb;
    int          hs_idx;
    int          first_vld;
    int          done_idx;
    logic [31:0] pd;
    logic        pv, pl, prdy, pcenlo;
    logic [2:0]  pa;
    logic [31:0] e_idx;
    nb = 0; hs_idx = -1; first_vld = -1; done_idx = -1;
    pd = '0; pv = 1'b0; pl = 1'b0; prdy = 1'b1; pcenlo = 1'b0; pa = '0;
    e_idx = exp_idx;
    @(negedge clk_i);
    start_i = 1'b1; first_i = f; count_i = c; cen_i = 1'b1;
    m_if.m_tready_i = rdy_pat[0];
    for (int i = 1; i < 60; i++) begin
      @(negedge clk_i);
      start_i = (i == inj_idx);
      if (i == inj_idx) first_i = f + 3'd1;
      cen_i = !cenlo_pat[i];
      m_if.m_tready_i = rdy_pat[i];
      if (i == 1) begin
        chk({name, " raddr"}, 32'(raddr_o), 32'(f));
        chk({name, " busy"}, 32'(busy_o), 32'd1);
      end
      if (i > 1 && pcenlo) begin
        chk({name, " frozen data"}, m_if.m_tdata_o, pd);
        chk({name, " frozen valid"}, 32'(m_if.m_tvalid_o), 32'(pv));
        chk({name, " frozen last"}, 32'(m_if.m_tlast_o), 32'(pl));
        chk({name, " frozen raddr"}, 32'(raddr_o), 32'(pa));
      end else if (pv && !prdy) begin
        chk({name, " stall valid"}, 32'(m_if.m_tvalid_o), 32'd1);
        chk({name, " stall data"}, m_if.m_tdata_o, pd);
      end
      if (m_if.m_tvalid_o && first_vld < 0) first_vld = i;
      if (done_o) begin
        done_idx = i;
        break;
      end
      if (m_if.m_tvalid_o && m_if.m_tready_i && cen_i) begin
        if (nb < exp_n)
          chk({name, " beat data"}, m_if.m_tdata_o, 32'h100 + 32'(e_idx[4*nb +: 4]));
        chk({name, " beat last"}, 32'(m_if.m_tlast_o), 32'(nb == exp_n - 1));
        nb++;
        hs_idx = i;
      end
      pd = m_if.m_tdata_o; pv = m_if.m_tvalid_o; pl = m_if.m_tlast_o;
      prdy = m_if.m_tready_i; pcenlo = !cen_i; pa = raddr_o;
    end
    start_i = 1'b0; cen_i = 1'b1; m_if.m_tready_i = 1'b1;
    chk({name, " done seen"}, 32'(done_idx >= 0), 32'd1);
    chk({name, " beat count"}, 32'(nb), 32'(exp_n));
    if (exp_n > 0) begin
      chk({name, " first valid cycle"}, 32'(first_vld), 32'd2);
      chk({name, " done after last"}, 32'(done_idx), 32'(hs_idx + 1));
    end else begin
      chk({name, " empty done cycle"}, 32'(done_idx), 32'd1);
    end
    @(negedge clk_i);
    chk({name, " done pulse width"}, 32'(done_o), 32'd0);
    chk({name, " idle busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + 32'(i);
    cen_i = 1'b1; rst_i = 1'b1; start_i = 1'b0; first_i = '0; count_i = '0;
    m_if.m_tready_i = 1'b1;

    vecs[0] = '{3'd2, 4'd3,  3, 32'h0000_0432};
`ifdef IOB_REGFILE_2P_READER_WRAP_EN
    vecs[1] = '{3'd6, 4'd4,  4, 32'h0000_1076};
    vecs[5] = '{3'd7, 4'd8,  8, 32'h6543_2107};
`else
    vecs[1] = '{3'd6, 4'd4,  2, 32'h0000_0076};
    vecs[5] = '{3'd7, 4'd8,  1, 32'h0000_0007};
`endif
    vecs[2] = '{3'd0, 4'd0,  0, 32'h0000_0000};
    vecs[3] = '{3'd0, 4'd12, 8, 32'h7654_3210};
    vecs[4] = '{3'd5, 4'd1,  1, 32'h0000_0005};

    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst raddr", 32'(raddr_o), 32'd0);
    chk("rst tdata", m_if.m_tdata_o, 32'd0);
    chk("rst tvalid", 32'(m_if.m_tvalid_o), 32'd0);
    chk("rst tlast", 32'(m_if.m_tlast_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);

    for (int v = 0; v < 6; v++)
      run_req($sformatf("vec%0d", v), vecs[v].first, vecs[v].count, 32'hFFFF_FFFF, 32'h0,
              -1, vecs[v].idx, vecs[v].n);

    // 0x103 is presented in cycle 3; hold ready low for cycles 3..5
    run_req("backpressure", 3'd2, 4'd3, 32'hFFFF_FFC7, 32'h0, -1, 32'h0000_0432, 3);
    run_req("start ignored", 3'd2, 4'd3, 32'hFFFF_FFFF, 32'h0, 3, 32'h0000_0432, 3);
    run_req("cen freeze", 3'd2, 4'd3, 32'hFFFF_FFFF, 32'h0000_0018, -1, 32'h0000_0432, 3);

    // Reset after the second beat of an 8-beat packet
    @(negedge clk_i);
    start_i = 1'b1; first_i = 3'd0; count_i = 4'd8; m_if.m_tready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    chk("mid rst second beat", m_if.m_tdata_o, 32'h101);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid rst tvalid", 32'(m_if.m_tvalid_o), 32'd0);
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst tlast", 32'(m_if.m_tlast_o), 32'd0);
    chk("mid rst done", 32'(done_o), 32'd0);
    run_req("after rst", 3'd0, 4'd1, 32'hFFFF_FFFF, 32'h0, -1, 32'h0000_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
